// File: rtl/stepper_seq.sv
// stepper_seq: N-channel stepper dispense sequencer.
// After a start pulse, each channel with a nonzero depth runs in turn:
// forward `depth` steps, dwell with coils off, reverse back, then the next channel.
// Optional half-step drive is enabled by defining STEPPER_SEQ_HALF_STEP_EN.
module stepper_seq #(
  parameter int NCH   = 3,
  parameter int CW    = 10,
  parameter int CHW   = 2,
  parameter int DIV_W = 22
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [NCH*CW-1:0] depth,
  input  logic [NCH*CW-1:0] dwell,
  output logic [NCH*4-1:0]  phase,
  output logic [CHW-1:0]    active_ch,
  output logic              busy,
  output logic              done
);

`ifdef STEPPER_SEQ_HALF_STEP_EN
  localparam int IW = 3;
`else
  localparam int IW = 2;
`endif

  typedef enum logic [2:0] {
    ST_IDLE, ST_ARM, ST_FWD, ST_DWELL, ST_REV, ST_NEXT, ST_DONE
  } state_t;

  // Coil pattern for a given step index; the index wraps naturally at 2^IW.
  function automatic logic [3:0] coil_pat(input logic [IW-1:0] i);
    logic [3:0] p;
    p = 4'b0000;
`ifdef STEPPER_SEQ_HALF_STEP_EN
    case (i)
      3'd0:    p = 4'b0001;
      3'd1:    p = 4'b1001;
      3'd2:    p = 4'b1000;
      3'd3:    p = 4'b1100;
      3'd4:    p = 4'b0100;
      3'd5:    p = 4'b0110;
      3'd6:    p = 4'b0010;
      3'd7:    p = 4'b0011;
      default: p = 4'b0000;
    endcase
`else
    case (i)
      2'd0:    p = 4'b0001;
      2'd1:    p = 4'b1000;
      2'd2:    p = 4'b0100;
      2'd3:    p = 4'b0010;
      default: p = 4'b0000;
    endcase
`endif
    return p;
  endfunction

  state_t            state, state_n;
  logic [DIV_W-1:0]  div_cnt;
  logic              tick;
  logic [CW-1:0]     depth_q [NCH];
  logic [CW-1:0]     dwell_q [NCH];
  logic [CW-1:0]     cnt, cnt_n, cnt_inc;
  logic [CW-1:0]     cur_depth, cur_dwell, dwell_len;
  logic [IW-1:0]     idx [NCH];
  logic [IW-1:0]     idx_n [NCH];
  logic [IW-1:0]     cur_idx, step_idx;
  logic              drive_step;
  logic [NCH*4-1:0]  phase_n;
  logic [CHW-1:0]    ch_n, found_ch;
  logic              found, load;
  int                search_from;

  // Free-running step divider; tick marks the all-ones count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_cnt <= '0;
    else     div_cnt <= div_cnt + 1'b1;
  end

  assign tick = &div_cnt;

  // Capture the recipe on an accepted start so later input changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NCH; k++) begin
        depth_q[k] <= '0;
        dwell_q[k] <= '0;
      end
    end else if (load) begin
      for (int k = 0; k < NCH; k++) begin
        depth_q[k] <= depth[k*CW +: CW];
        dwell_q[k] <= dwell[k*CW +: CW];
      end
    end
  end

  // State, counters, step indices and coil outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      phase     <= '0;
      active_ch <= '0;
      for (int k = 0; k < NCH; k++) idx[k] <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      phase     <= phase_n;
      active_ch <= ch_n;
      for (int k = 0; k < NCH; k++) idx[k] <= idx_n[k];
    end
  end

  // Active-channel view of the recipe and search for the next channel with work.
  always_comb begin
    cur_depth = '0;
    cur_dwell = '0;
    cur_idx   = '0;
    for (int k = 0; k < NCH; k++) begin
      if (CHW'(k) == active_ch) begin
        cur_depth = depth_q[k];
        cur_dwell = dwell_q[k];
        cur_idx   = idx[k];
      end
    end
    dwell_len   = (cur_dwell == '0) ? CW'(1) : cur_dwell;
    cnt_inc     = cnt + 1'b1;
    search_from = (state == ST_ARM) ? 0 : int'(active_ch) + 1;
    found       = 1'b0;
    found_ch    = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (k >= search_from && depth_q[k] != '0) begin
        found    = 1'b1;
        found_ch = CHW'(k);
      end
    end
  end

  // Next-state logic; stop overrides everything and returns to a clean idle.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    idx_n      = idx;
    phase_n    = phase;
    ch_n       = active_ch;
    load       = 1'b0;
    drive_step = 1'b0;
    step_idx   = cur_idx;

    case (state)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          cnt_n   = '0;
          state_n = ST_ARM;
        end
      end
      ST_ARM: begin
        if (tick) begin
          cnt_n = '0;
          if (found) begin
            ch_n    = found_ch;
            state_n = ST_FWD;
          end else begin
            state_n = ST_DONE;
          end
        end
      end
      ST_FWD: begin
        if (tick) begin
          drive_step = 1'b1;
          step_idx   = cur_idx + 1'b1;
          if (cnt_inc == cur_depth) begin
            cnt_n   = '0;
            state_n = ST_DWELL;
          end else begin
            cnt_n = cnt_inc;
          end
        end
      end
      ST_DWELL: begin
        if (tick) begin
          phase_n = '0;
          if (cnt_inc >= dwell_len) begin
            cnt_n   = '0;
            state_n = ST_REV;
          end else begin
            cnt_n = cnt_inc;
          end
        end
      end
      ST_REV: begin
        if (tick) begin
          drive_step = 1'b1;
          step_idx   = cur_idx - 1'b1;
          if (cnt_inc == cur_depth) begin
            cnt_n   = '0;
            state_n = ST_NEXT;
          end else begin
            cnt_n = cnt_inc;
          end
        end
      end
      ST_NEXT: begin
        if (tick) begin
          phase_n = '0;
          cnt_n   = '0;
          if (found) begin
            ch_n    = found_ch;
            state_n = ST_FWD;
          end else begin
            state_n = ST_DONE;
          end
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase

    if (drive_step) begin
      phase_n = '0;
      for (int k = 0; k < NCH; k++) begin
        if (CHW'(k) == active_ch) begin
          idx_n[k]          = step_idx;
          phase_n[k*4 +: 4] = coil_pat(step_idx);
        end
      end
    end

    if (stop) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
      phase_n = '0;
      load    = 1'b0;
      for (int k = 0; k < NCH; k++) idx_n[k] = '0;
    end
  end

  assign busy = (state != ST_IDLE) && (state != ST_DONE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_stepper_seq.sv
// tb_stepper_seq: bench for stepper_seq with a tick-level schedule model.
// Honours STEPPER_SEQ_HALF_STEP_EN the same way as the design.
module tb_stepper_seq;
  localparam int NCH   = 3;
  localparam int CW    = 4;
  localparam int CHW   = 2;
  localparam int DIV_W = 2;
`ifdef STEPPER_SEQ_HALF_STEP_EN
  localparam int L = 8;
`else
  localparam int L = 4;
`endif

  logic        clk, rst, start, stop;
  logic [11:0] depth, dwell;
  logic [11:0] phase;
  logic [1:0]  active_ch;
  logic        busy, done;

  stepper_seq #(.NCH(NCH), .CW(CW), .CHW(CHW), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .depth(depth), .dwell(dwell), .phase(phase),
    .active_ch(active_ch), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One entry per tick of a run: what the outputs become after that tick.
  typedef struct {
    logic [11:0] ph;
    int          act;
    int          kind;
  } rec_t;

  rec_t        sched[$];
  rec_t        last_sched[$];
  logic [3:0]  pat_tb [8];
  logic [3:0]  exp_nib [8];
  int          m_state, m_div, m_act, m_kind;
  logic [11:0] m_phase;
  logic        m_busy, m_done;
  int          n_checks = 0;
  int          n_pass = 0;

  initial begin
`ifdef STEPPER_SEQ_HALF_STEP_EN
    pat_tb[0] = 4'b0001; pat_tb[1] = 4'b1001; pat_tb[2] = 4'b1000; pat_tb[3] = 4'b1100;
    pat_tb[4] = 4'b0100; pat_tb[5] = 4'b0110; pat_tb[6] = 4'b0010; pat_tb[7] = 4'b0011;
`else
    pat_tb[0] = 4'b0001; pat_tb[1] = 4'b1000; pat_tb[2] = 4'b0100; pat_tb[3] = 4'b0010;
    for (int i = 4; i < 8; i++) pat_tb[i] = 4'b0000;
`endif
  end

  function automatic logic [11:0] place(input int c, input logic [3:0] p);
    logic [11:0] v;
    v = '0;
    v[c*4 +: 4] = p;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, want, $time);
  endtask

  // Expand a recipe into the full per-tick output list, starting with the ARM tick.
  task automatic buildSched(input logic [11:0] d, input logic [11:0] w);
    int   chs[$];
    int   c, dep, dw, pos;
    rec_t r;
    sched.delete();
    for (int k = 0; k < NCH; k++) if (d[k*4 +: 4] != 4'd0) chs.push_back(k);
    r.ph = '0; r.act = (chs.size() > 0) ? chs[0] : m_act; r.kind = 0;
    sched.push_back(r);
    for (int i = 0; i < chs.size(); i++) begin
      c = chs[i];
      dep = int'(d[c*4 +: 4]);
      dw = int'(w[c*4 +: 4]);
      if (dw == 0) dw = 1;
      pos = 0;
      for (int s = 0; s < dep; s++) begin
        pos = (pos + 1) % L;
        r.ph = place(c, pat_tb[pos]); r.act = c; r.kind = 1; sched.push_back(r);
      end
      for (int s = 0; s < dw; s++) begin
        r.ph = '0; r.act = c; r.kind = 2; sched.push_back(r);
      end
      for (int s = 0; s < dep; s++) begin
        pos = (pos + L - 1) % L;
        r.ph = place(c, pat_tb[pos]); r.act = c; r.kind = 3; sched.push_back(r);
      end
      r.ph = '0; r.act = (i + 1 < chs.size()) ? chs[i+1] : c; r.kind = 4;
      sched.push_back(r);
    end
    last_sched = sched;
  endtask

  task automatic modelStep();
    bit   tk;
    rec_t r;
    if (rst) begin
      m_state = 0; m_div = 0; m_phase = '0; m_act = 0;
      m_busy = 1'b0; m_done = 1'b0; m_kind = -1; sched.delete();
    end else begin
      tk = (m_div == (1 << DIV_W) - 1);
      m_div = (m_div + 1) % (1 << DIV_W);
      if (stop) begin
        m_state = 0; m_phase = '0; m_busy = 1'b0; m_done = 1'b0; m_kind = -1;
        sched.delete();
      end else begin
        case (m_state)
          0: begin
            m_done = 1'b0;
            if (start) begin
              buildSched(depth, dwell);
              m_state = 1;
              m_busy = 1'b1;
            end
          end
          1: begin
            if (tk) begin
              r = sched.pop_front();
              m_phase = r.ph; m_act = r.act; m_kind = r.kind;
              if (sched.size() == 0) begin
                m_state = 2; m_busy = 1'b0; m_done = 1'b1;
              end
            end
          end
          default: begin
            m_done = 1'b0;
            m_state = 0;
          end
        endcase
      end
    end
  endtask

  // Advance the model on every edge and compare all outputs just after it.
  always begin
    @(posedge clk);
    modelStep();
    #1;
    checkOutput("phase", 32'(phase), 32'(m_phase));
    checkOutput("active_ch", 32'(active_ch), 32'(m_act));
    checkOutput("busy", 32'(busy), 32'(m_busy));
    checkOutput("done", 32'(done), 32'(m_done));
  end

  task automatic applyStimulus(input logic [11:0] d, input logic [11:0] w);
    @(negedge clk);
    depth = d; dwell = w; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitIdle(output int pulses);
    int guard;
    guard = 0;
    pulses = 0;
    while (m_state != 0 && guard < 2000) begin
      @(negedge clk);
      if (done) pulses++;
      guard++;
    end
    if (m_state != 0) begin
      n_checks++;
      $display("[TB] FAIL timeout: run still active after %0d cycles, expected idle", guard);
    end
  endtask

  initial begin
    int pulses, guard;
    logic [11:0] rd, rw;
    rst = 1'b1; start = 1'b0; stop = 1'b0; depth = '0; dwell = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] basic run with late start and input change");
    applyStimulus(12'h312, 12'h201);
`ifdef STEPPER_SEQ_HALF_STEP_EN
    exp_nib[0] = 4'b1001; exp_nib[1] = 4'b1000; exp_nib[2] = 4'b0000;
    exp_nib[3] = 4'b1001; exp_nib[4] = 4'b0001; exp_nib[5] = 4'b0000;
`else
    exp_nib[0] = 4'b1000; exp_nib[1] = 4'b0100; exp_nib[2] = 4'b0000;
    exp_nib[3] = 4'b1000; exp_nib[4] = 4'b0001; exp_nib[5] = 4'b0000;
`endif
    checkOutput("basic_ticks", 32'(last_sched.size()), 32'd20);
    for (int k = 0; k < 6; k++) begin
      checkOutput($sformatf("basic_ch0_tick%0d", k), 32'(last_sched[k+1].ph), 32'(exp_nib[k]));
      checkOutput($sformatf("basic_act_tick%0d", k), 32'(last_sched[k+1].act), (k == 5) ? 32'd1 : 32'd0);
    end
    repeat (10) @(negedge clk);
    depth = 12'hfff; dwell = 12'hfff; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitIdle(pulses);
    checkOutput("basic_done_pulses", 32'(pulses), 32'd1);

    $display("[TB] skip channels 0 and 2");
    applyStimulus(12'h020, 12'h000);
    checkOutput("skip_ticks", 32'(last_sched.size()), 32'd7);
    for (int k = 0; k < 7; k++)
      checkOutput($sformatf("skip_act_tick%0d", k), 32'(last_sched[k].act), 32'd1);
    waitIdle(pulses);
    checkOutput("skip_done_pulses", 32'(pulses), 32'd1);

    $display("[TB] all-zero depth");
    applyStimulus(12'h000, 12'h555);
    checkOutput("zero_ticks", 32'(last_sched.size()), 32'd1);
    waitIdle(pulses);
    checkOutput("zero_done_pulses", 32'(pulses), 32'd1);

    $display("[TB] abort during channel 1 reverse");
    applyStimulus(12'h322, 12'h201);
    guard = 0;
    while (!(m_kind == 3 && m_act == 1) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (m_kind == 3 && m_act == 1) begin
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      checkOutput("abort_phase", 32'(phase), 32'd0);
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_done", 32'(done), 32'd0);
      pulses = 0;
      repeat (6) begin
        @(negedge clk);
        if (done) pulses++;
      end
      checkOutput("abort_no_done", 32'(pulses), 32'd0);
    end else begin
      n_checks++;
      $display("[TB] FAIL abort_reach: channel 1 reverse not seen within %0d cycles", guard);
    end
    applyStimulus(12'h312, 12'h201);
    waitIdle(pulses);
    checkOutput("restart_done_pulses", 32'(pulses), 32'd1);

    $display("[TB] single channel depth 3, zero dwell");
    applyStimulus(12'h003, 12'h000);
`ifdef STEPPER_SEQ_HALF_STEP_EN
    exp_nib[0] = 4'b1001; exp_nib[1] = 4'b1000; exp_nib[2] = 4'b1100; exp_nib[3] = 4'b0000;
    exp_nib[4] = 4'b1000; exp_nib[5] = 4'b1001; exp_nib[6] = 4'b0001; exp_nib[7] = 4'b0000;
`else
    exp_nib[0] = 4'b1000; exp_nib[1] = 4'b0100; exp_nib[2] = 4'b0010; exp_nib[3] = 4'b0000;
    exp_nib[4] = 4'b0100; exp_nib[5] = 4'b1000; exp_nib[6] = 4'b0001; exp_nib[7] = 4'b0000;
`endif
    checkOutput("single_ticks", 32'(last_sched.size()), 32'd9);
    for (int k = 0; k < 8; k++)
      checkOutput($sformatf("single_ch0_tick%0d", k), 32'(last_sched[k+1].ph), 32'(exp_nib[k]));
    waitIdle(pulses);
    checkOutput("single_done_pulses", 32'(pulses), 32'd1);

    $display("[TB] randomized runs");
    for (int r = 0; r < 40; r++) begin
      for (int c = 0; c < NCH; c++) begin
        rd[c*4 +: 4] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 4));
        rw[c*4 +: 4] = 4'($urandom_range(0, 3));
      end
      applyStimulus(rd, rw);
      guard = 0;
      while (m_state != 0 && guard < 2000) begin
        @(negedge clk);
        start = ($urandom_range(0, 19) == 0);
        depth = 12'($urandom);
        dwell = 12'($urandom);
        stop = (r % 4 == 3) ? ($urandom_range(0, 79) == 0) : 1'b0;
        if (r == 21 && guard == 30) rst = 1'b1;
        guard++;
      end
      start = 1'b0; stop = 1'b0;
      if (rst) begin
        @(negedge clk);
        rst = 1'b0;
      end
      if (m_state != 0) begin
        n_checks++;
        $display("[TB] FAIL random_timeout: run %0d still active, expected idle", r);
      end
      repeat ($urandom_range(1, 6)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
